audio_pwm_audout_nchan: RTL and testbench
=========================================

AUDIO_PWM_AUDOUT_NCHAN -- requirements
Module: audio_pwm_audout_nchan

Interface
REQ-001 Parameter BITRES, default 8, meaning amplitude resolution in bits; the period is 2^BITRES clocks.
REQ-002 Parameter NCHAN, default 2, meaning number of output channels.
REQ-003 Parameter MODE, default 0, meaning modulation: 0 = PWM, 1 = first-order sigma-delta.
REQ-004 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 mute  in  1  global synchronous mute, active-high.
REQ-007 chan_mute  in  NCHAN  per-channel mute; bit ch forces audout[ch] low.
REQ-008 sample_in  in  NCHAN*BITRES  packed samples; channel ch occupies bits [ch*BITRES +: BITRES].
REQ-009 sample_valid  in  1  sample_in is offered this cycle.
REQ-010 sample_ready  out  1  the block accepts sample_in this cycle.
REQ-011 audout  out  NCHAN  registered 1-bit audio outputs.
REQ-012 period_start  out  1  registered one-cycle pulse marking the first output cycle of each period.

Function
REQ-013 Shared counter count[BITRES-1:0]: increments by 1 every clk while mute=0 and wraps from 2^BITRES-1 to 0; wrap = (count == 2^BITRES-1).
REQ-014 Double buffer: a pending register (NCHAN*BITRES bits) with flag pend_full feeds the active register (NCHAN*BITRES bits).
REQ-015 sample_ready = ~pend_full & ~mute (combinational).
REQ-016 Accept = sample_valid & sample_ready: pending <= sample_in and pend_full <= 1.
REQ-017 On a wrap cycle with pend_full=1: active <= pending and pend_full <= 0; sample_ready returns high the next cycle.
REQ-018 An accept on a wrap cycle (pend_full was 0) loads pending only; it is applied at the following wrap.
REQ-019 Samples never change mid-period; the active value is constant across all 2^BITRES cycles of a period.
REQ-020 MODE=0: audout[ch] <= (count < active[ch]); value 0 gives constant 0, value 2^BITRES-1 gives high for 2^BITRES-1 of 2^BITRES cycles.
REQ-021 MODE=1: per-channel accumulator acc[ch] of BITRES+1 bits; each cycle acc <= {0, acc[BITRES-1:0]} + active[ch] and audout[ch] <= carry bit of that sum; the high-cycle count per period equals active[ch] exactly.
REQ-022 chan_mute[ch]=1: audout[ch] <= 0 on the next edge; in MODE=1, acc[ch] is held at 0; the counter and other channels are unaffected.
REQ-023 period_start <= (count == 0) & ~mute; it is therefore high in the same cycle that audout first reflects count=0.
REQ-024 Output latency: audout reflects the count value of the previous cycle (1 clk, registered).
REQ-025 mute=1 (synchronous, priority over all else except resetn): count, all acc, audout and period_start become 0; pending, pend_full and active hold their values; no accept occurs.
REQ-026 After mute deasserts, counting resumes from count=0 and period_start pulses one clk later.

Reset
REQ-027 On resetn=0, asynchronously: count=0, pend_full=0, pending=0, active=0, acc=0, audout=0, period_start=0; sample_ready is 1 once resetn=1 and mute=0.
REQ-028 Reset asserted mid-period discards any pending and active samples; the first period after release outputs zeros until a sample is accepted and a wrap occurs.

Verification (BITRES=4, NCHAN=2)
REQ-029 MODE=0, accept ch0=4, ch1=15 -> after the next wrap, each 16-clk period has audout[0] high for 4 clks (count 0..3) and audout[1] high for 15 clks; period_start pulses every 16 clks.
REQ-030 MODE=1, active ch0=8 -> audout[0] alternates 0,1,0,1...; ch0=0 -> constant 0; ch0=15 -> exactly 15 highs per 16 clks.
REQ-031 Handshake: accept a sample at count=3, hold sample_valid -> sample_ready=0 until the cycle after count=15; the new value is visible from period_start; the second sample is accepted then.
REQ-032 mute pulsed at count=9 for 3 clks -> audout=0 and count=0 during mute; after release, period_start occurs 1 clk later with the active value unchanged.
REQ-033 chan_mute[1]=1 mid-period -> audout[1]=0 from the next edge while audout[0] and period_start are unaffected.
REQ-034 resetn pulsed low with pend_full=1 and active nonzero -> all outputs are 0 immediately; sample_ready=1 after release; outputs stay 0 until a new accept and a wrap.

Source files
------------

// File: rtl/audio_pwm_audout_nchan.sv
// audio_pwm_audout_nchan
//
// Multi-channel 1-bit audio output stage. One shared period counter of 2^BITRES clocks drives
// NCHAN channels. Each channel turns its active amplitude into a bit stream, either as plain PWM
// (MODE=0) or as first-order sigma-delta (MODE=1). New samples pass through a one-deep pending
// buffer and become active only at a period boundary, so a period never mixes two samples.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   resetn        asynchronous active-low reset
//   mute          synchronous global mute: clears counter, accumulators and outputs
//   chan_mute     per-channel mute, bit ch forces audout[ch] low
//   sample_in     packed samples, channel ch at [ch*BITRES +: BITRES]
//   sample_valid  sample_in is offered this cycle
//   sample_ready  the pending buffer can take sample_in this cycle
//   audout        registered 1-bit audio outputs, one per channel
//   period_start  registered pulse on the first output cycle of each period

module audio_pwm_audout_nchan #(
  parameter int unsigned BITRES = 8,
  parameter int unsigned NCHAN  = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mute,
  input  logic [NCHAN-1:0]        chan_mute,
  input  logic [NCHAN*BITRES-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic [NCHAN-1:0]        audout,
  output logic                    period_start
);

  localparam logic [BITRES-1:0] CountMax = {BITRES{1'b1}};

  // Shared period counter
  logic [BITRES-1:0] count_q, count_d;
  logic              wrap;

  // Double buffer: pending holds the next sample set, active drives the modulators
  logic [NCHAN*BITRES-1:0] pending_q, pending_d;
  logic [NCHAN*BITRES-1:0] active_q, active_d;
  logic                    pend_full_q, pend_full_d;
  logic                    accept;

  // Sigma-delta residue per channel. Only the low BITRES bits of the accumulator are kept as
  // state; the carry of each sum is the channel output and lives in audout_q.
  logic [NCHAN*BITRES-1:0] acc_q, acc_d;

  logic [NCHAN-1:0] audout_q, audout_d;
  logic             period_start_q, period_start_d;

  // Per-channel scratch values for the output loop
  logic [BITRES-1:0] ch_val;
  logic [BITRES:0]   ch_sum;

  // Counter and handshake
  always_comb begin
    wrap         = (count_q == CountMax);
    count_d      = mute ? '0 : count_q + BITRES'(1);
    sample_ready = ~pend_full_q & ~mute;
    accept       = sample_valid & sample_ready;
  end

  // Buffer update. An accept needs an empty pending buffer, so it can never coincide with a
  // transfer; an accept on a wrap cycle therefore waits for the following wrap. Mute freezes
  // both registers.
  always_comb begin
    pending_d   = pending_q;
    active_d    = active_q;
    pend_full_d = pend_full_q;
    if (accept) begin
      pending_d   = sample_in;
      pend_full_d = 1'b1;
    end else if (!mute && wrap && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
  end

  // Modulators. Outputs always use the current active value and count, so the first output
  // cycle of a period (count=0) already reflects a sample transferred at the preceding wrap.
  always_comb begin
    acc_d    = acc_q;
    audout_d = '0;
    ch_val   = '0;
    ch_sum   = '0;
    for (int unsigned ch = 0; ch < NCHAN; ch++) begin
      ch_val = active_q[ch*BITRES +: BITRES];
      ch_sum = {1'b0, acc_q[ch*BITRES +: BITRES]} + {1'b0, ch_val};
      if (mute || chan_mute[ch]) begin
        acc_d[ch*BITRES +: BITRES] = '0;
        audout_d[ch]               = 1'b0;
      end else if (MODE == 1) begin
        // Residue wraps modulo 2^BITRES; over one full period the carries add up to ch_val.
        acc_d[ch*BITRES +: BITRES] = ch_sum[BITRES-1:0];
        audout_d[ch]               = ch_sum[BITRES];
      end else begin
        acc_d[ch*BITRES +: BITRES] = '0;
        audout_d[ch]               = (count_q < ch_val);
      end
    end
  end

  always_comb begin
    period_start_d = (count_q == '0) & ~mute;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q        <= '0;
      pending_q      <= '0;
      active_q       <= '0;
      pend_full_q    <= 1'b0;
      acc_q          <= '0;
      audout_q       <= '0;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      pending_q      <= pending_d;
      active_q       <= active_d;
      pend_full_q    <= pend_full_d;
      acc_q          <= acc_d;
      audout_q       <= audout_d;
      period_start_q <= period_start_d;
    end
  end

  assign audout       = audout_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_audio_pwm_audout_nchan.sv
// Bench for audio_pwm_audout_nchan with BITRES=4, NCHAN=2. A PWM instance and a sigma-delta
// instance share all inputs; a cycle model of the described behaviour runs alongside.

module tb_audio_pwm_audout_nchan;

  logic       clk = 1'b0;
  logic       resetn;
  logic       mute;
  logic [1:0] chan_mute;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sr0, sr1, ps0, ps1;
  logic [1:0] ao0, ao1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_pwm_audout_nchan #(.BITRES(4), .NCHAN(2), .MODE(0)) u_pwm (
    .clk(clk), .resetn(resetn), .mute(mute), .chan_mute(chan_mute), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sr0), .audout(ao0), .period_start(ps0)
  );

  audio_pwm_audout_nchan #(.BITRES(4), .NCHAN(2), .MODE(1)) u_sd (
    .clk(clk), .resetn(resetn), .mute(mute), .chan_mute(chan_mute), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sr1), .audout(ao1), .period_start(ps1)
  );

  // Reference model: period position, buffered samples, sigma-delta residue, expected outputs
  int m_cnt;
  int m_pend [2];
  int m_act  [2];
  int m_acc  [2];
  bit m_pfull;
  bit m_out0 [2];
  bit m_out1 [2];
  bit m_ps;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt   <= 0;
      m_pfull <= 0;
      m_ps    <= 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_pend[ch] <= 0; m_act[ch] <= 0; m_acc[ch] <= 0; m_out0[ch] <= 0; m_out1[ch] <= 0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (mute || chan_mute[ch]) begin
          m_out0[ch] <= 0; m_out1[ch] <= 0; m_acc[ch] <= 0;
        end else begin
          m_out0[ch] <= (m_cnt < m_act[ch]);
          m_acc[ch]  <= (m_acc[ch] % 16) + m_act[ch];
          m_out1[ch] <= ((m_acc[ch] % 16) + m_act[ch]) >= 16;
        end
      end
      m_ps  <= (m_cnt == 0) && !mute;
      m_cnt <= mute ? 0 : (m_cnt + 1) % 16;
      if (sample_valid && !m_pfull && !mute) begin
        m_pend[0] <= int'(sample_in[3:0]);
        m_pend[1] <= int'(sample_in[7:4]);
        m_pfull   <= 1;
      end else if (!mute && m_cnt == 15 && m_pfull) begin
        m_act[0] <= m_pend[0];
        m_act[1] <= m_pend[1];
        m_pfull  <= 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one sample pair, then return at the negedge where the period that plays it starts.
  task automatic load_pair(input int v0, input int v1, output bit ok);
    int t;
    ok = 1;
    t  = 0;
    while (m_pfull && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) ok = 0;
    sample_in    = {v1[3:0], v0[3:0]};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    t = 0;
    while (m_pfull && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) ok = 0;
    t = 0;
    while (ps0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) ok = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; mute = 1'b0; chan_mute = 2'b00; sample_valid = 1'b0; sample_in = 8'h00;
    repeat (3) @(negedge clk);
    n_tests++; if (ao0 !== 2'b00) begin n_fail++; $display("FAIL reset_audout_pwm: got %b want 00", ao0); end
    n_tests++; if (ao1 !== 2'b00) begin n_fail++; $display("FAIL reset_audout_sd: got %b want 00", ao1); end
    n_tests++; if (ps0 !== 1'b0 || ps1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_period_start: got %b%b want 00", ps0, ps1);
    end
    resetn = 1'b1;
    #1;
    n_tests++; if (sr0 !== 1'b1 || sr1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b%b want 11", sr0, sr1);
    end
    @(negedge clk);
    n_tests++; if (ps0 !== 1'b1 || ps1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_period_start: got %b%b want 11", ps0, ps1);
    end
    n_tests++; if (ao0 !== 2'b00 || ao1 !== 2'b00) begin
      n_fail++; $display("FAIL reset_zero_output: got %b %b want 00 00", ao0, ao1);
    end
  endtask

  task automatic test_pwm();
    bit ok;
    int h_sd0, h_sd1;
    h_sd0 = 0; h_sd1 = 0;
    load_pair(4, 15, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL pwm_load: got timeout want transfer"); end
    for (int i = 0; i < 32; i++) begin
      n_tests++; if (ao0[0] !== ((i % 16) < 4)) begin
        n_fail++; $display("FAIL pwm_ch0 cyc %0d: got %b want %b", i, ao0[0], (i % 16) < 4);
      end
      n_tests++; if (ao0[1] !== ((i % 16) < 15)) begin
        n_fail++; $display("FAIL pwm_ch1 cyc %0d: got %b want %b", i, ao0[1], (i % 16) < 15);
      end
      n_tests++; if (ps0 !== ((i % 16) == 0) || ps1 !== ps0) begin
        n_fail++; $display("FAIL pwm_period_start cyc %0d: got %b%b want %b", i, ps0, ps1, (i % 16) == 0);
      end
      h_sd0 += int'(ao1[0]);
      h_sd1 += int'(ao1[1]);
      @(negedge clk);
    end
    n_tests++; if (h_sd0 != 8) begin n_fail++; $display("FAIL sd_count_4: got %0d want 8", h_sd0); end
    n_tests++; if (h_sd1 != 30) begin n_fail++; $display("FAIL sd_count_15: got %0d want 30", h_sd1); end
  endtask

  task automatic test_sigma_delta();
    bit ok;
    bit prev;
    int h0, h1, p0;
    load_pair(8, 0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sd_load8: got timeout want transfer"); end
    h0 = 0; prev = ao1[0];
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        n_tests++; if (ao1[0] === prev) begin
          n_fail++; $display("FAIL sd_alternate cyc %0d: got %b want %b", i, ao1[0], ~prev);
        end
      end
      n_tests++; if (ao1[1] !== 1'b0 || ao0[1] !== 1'b0) begin
        n_fail++; $display("FAIL sd_zero cyc %0d: got %b %b want 0 0", i, ao1[1], ao0[1]);
      end
      prev = ao1[0];
      h0 += int'(ao1[0]);
      @(negedge clk);
    end
    n_tests++; if (h0 != 16) begin n_fail++; $display("FAIL sd_count_8: got %0d want 16", h0); end
    load_pair(15, 3, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL sd_load15: got timeout want transfer"); end
    h0 = 0; h1 = 0; p0 = 0;
    for (int i = 0; i < 32; i++) begin
      h0 += int'(ao1[0]);
      h1 += int'(ao1[1]);
      p0 += int'(ao0[0]);
      @(negedge clk);
    end
    n_tests++; if (h0 != 30) begin n_fail++; $display("FAIL sd_count_15b: got %0d want 30", h0); end
    n_tests++; if (h1 != 6) begin n_fail++; $display("FAIL sd_count_3: got %0d want 6", h1); end
    n_tests++; if (p0 != 30) begin n_fail++; $display("FAIL pwm_count_15: got %0d want 30", p0); end
  endtask

  task automatic test_handshake();
    int t, h0, h1;
    t = 0;
    while (!(m_cnt == 3 && !m_pfull) && t < 40) begin @(negedge clk); t++; end
    n_tests++; if (t >= 40) begin n_fail++; $display("FAIL hs_sync: got timeout want count 3"); end
    sample_in    = {4'd0, 4'd9};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_in = {4'd11, 4'd5};
    t = 0;
    while (m_cnt != 0 && t < 20) begin
      n_tests++; if (sr0 !== 1'b0 || sr1 !== 1'b0) begin
        n_fail++; $display("FAIL hs_ready_low cnt %0d: got %b%b want 00", m_cnt, sr0, sr1);
      end
      @(negedge clk);
      t++;
    end
    n_tests++; if (sr0 !== 1'b1 || sr1 !== 1'b1) begin
      n_fail++; $display("FAIL hs_ready_after_wrap: got %b%b want 11", sr0, sr1);
    end
    @(negedge clk);
    sample_valid = 1'b0;
    n_tests++; if (ps0 !== 1'b1) begin n_fail++; $display("FAIL hs_period_start: got %b want 1", ps0); end
    n_tests++; if (ao0 !== 2'b01) begin n_fail++; $display("FAIL hs_first_value: got %b want 01", ao0); end
    n_tests++; if (sr0 !== 1'b0) begin n_fail++; $display("FAIL hs_second_pending: got %b want 0", sr0); end
    h0 = 0; h1 = 0;
    for (int i = 0; i < 16; i++) begin
      h0 += int'(ao0[0]); h1 += int'(ao0[1]);
      @(negedge clk);
    end
    n_tests++; if (h0 != 9 || h1 != 0) begin
      n_fail++; $display("FAIL hs_period_a: got %0d/%0d want 9/0", h0, h1);
    end
    n_tests++; if (ps0 !== 1'b1 || ao0 !== 2'b11) begin
      n_fail++; $display("FAIL hs_second_start: got ps %b out %b want ps 1 out 11", ps0, ao0);
    end
    h0 = 0; h1 = 0;
    for (int i = 0; i < 16; i++) begin
      h0 += int'(ao0[0]); h1 += int'(ao0[1]);
      @(negedge clk);
    end
    n_tests++; if (h0 != 5 || h1 != 11) begin
      n_fail++; $display("FAIL hs_period_b: got %0d/%0d want 5/11", h0, h1);
    end
  endtask

  task automatic test_mute();
    int t, h0, want0;
    logic [1:0] want_start;
    t = 0;
    while (m_cnt != 9 && t < 40) begin @(negedge clk); t++; end
    n_tests++; if (t >= 40) begin n_fail++; $display("FAIL mute_sync: got timeout want count 9"); end
    want0      = m_act[0];
    want_start = {m_act[1] != 0, m_act[0] != 0};
    mute = 1'b1;
    #1;
    n_tests++; if (sr0 !== 1'b0 || sr1 !== 1'b0) begin
      n_fail++; $display("FAIL mute_ready: got %b%b want 00", sr0, sr1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (ao0 !== 2'b00 || ao1 !== 2'b00 || ps0 !== 1'b0 || ps1 !== 1'b0) begin
        n_fail++; $display("FAIL mute_outputs cyc %0d: got %b %b %b%b want 00 00 00", i, ao0, ao1, ps0, ps1);
      end
    end
    mute = 1'b0;
    @(negedge clk);
    n_tests++; if (ps0 !== 1'b1 || ps1 !== 1'b1) begin
      n_fail++; $display("FAIL mute_release_start: got %b%b want 11", ps0, ps1);
    end
    n_tests++; if (ao0 !== want_start) begin
      n_fail++; $display("FAIL mute_release_out: got %b want %b", ao0, want_start);
    end
    h0 = 0;
    for (int i = 0; i < 16; i++) begin h0 += int'(ao0[0]); @(negedge clk); end
    n_tests++; if (h0 != want0) begin n_fail++; $display("FAIL mute_active_kept: got %0d want %0d", h0, want0); end
  endtask

  task automatic test_chan_mute();
    int t;
    t = 0;
    while (m_cnt != 6 && t < 40) begin @(negedge clk); t++; end
    chan_mute = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++; if (ao0[1] !== 1'b0 || ao1[1] !== 1'b0) begin
        n_fail++; $display("FAIL cmute_ch1 cyc %0d: got %b %b want 0 0", i, ao0[1], ao1[1]);
      end
      n_tests++; if (ao0[0] !== m_out0[0] || ao1[0] !== m_out1[0]) begin
        n_fail++; $display("FAIL cmute_ch0 cyc %0d: got %b %b want %b %b", i, ao0[0], ao1[0], m_out0[0], m_out1[0]);
      end
      n_tests++; if (ps0 !== m_ps) begin
        n_fail++; $display("FAIL cmute_period_start cyc %0d: got %b want %b", i, ps0, m_ps);
      end
    end
    chan_mute = 2'b00;
  endtask

  task automatic test_reset_mid();
    bit ok;
    load_pair(7, 12, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_load: got timeout want transfer"); end
    sample_in = 8'h33; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_tests++; if (ao0 !== 2'b00 || ao1 !== 2'b00 || ps0 !== 1'b0 || ps1 !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_outputs: got %b %b %b%b want 00 00 00", ao0, ao1, ps0, ps1);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_tests++; if (sr0 !== 1'b1 || sr1 !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready: got %b%b want 11", sr0, sr1);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_tests++; if (ao0 !== 2'b00 || ao1 !== 2'b00) begin
        n_fail++; $display("FAIL rst_stays_zero cyc %0d: got %b %b want 00 00", i, ao0, ao1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      n_tests++; if (ao0 !== {m_out0[1], m_out0[0]} || ao1 !== {m_out1[1], m_out1[0]}) begin
        n_fail++;
        $display("FAIL rand_audout cyc %0d: got %b %b want %b%b %b%b", i, ao0, ao1,
                 m_out0[1], m_out0[0], m_out1[1], m_out1[0]);
      end
      n_tests++; if (ps0 !== m_ps || ps1 !== m_ps) begin
        n_fail++; $display("FAIL rand_period_start cyc %0d: got %b%b want %b", i, ps0, ps1, m_ps);
      end
      n_tests++; if (sr0 !== (!m_pfull && !mute) || sr1 !== sr0) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %b%b want %b", i, sr0, sr1, !m_pfull && !mute);
      end
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_in    = 8'($urandom);
      if (mute) mute = ($urandom_range(0, 2) != 0);
      else      mute = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) chan_mute = 2'($urandom);
      if (!resetn)                         resetn = 1'b1;
      else if ($urandom_range(0, 699) == 0) resetn = 1'b0;
    end
    resetn = 1'b1; mute = 1'b0; chan_mute = 2'b00; sample_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_sigma_delta();
    test_handshake();
    test_mute();
    test_chan_mute();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
